// File: rtl/coffee_order_controller.sv
// Vending controller for three drinks: accepts coins up to a credit cap, hands a selection to the
// dispenser, and pays out change in 5-unit pulses.
module coffee_order_controller #(
  parameter int unsigned PRICE_A     = 15,
  parameter int unsigned PRICE_B     = 20,
  parameter int unsigned PRICE_C     = 25,
  parameter int unsigned MAX_CREDIT  = 75,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_i,
  input  logic       sel_valid_i,
  input  logic [1:0] sel_i,
  input  logic       cancel_i,
  input  logic       vend_ack_i,
  output logic       vend_go_o,
  output logic [1:0] vend_sel_o,
  output logic       coin_reject_o,
  output logic       change_pulse_o,
  output logic [6:0] credit_o,
  output logic       busy_o,
  output logic       fault_o
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e            state_q;
  logic [6:0]        credit_q;
  logic [6:0]        price_q;
  logic [1:0]        vend_sel_q;
  logic              vend_go_q;
  logic              coin_reject_q;
  logic              change_pulse_q;
  logic              busy_q;
  logic              fault_q;
  logic [TimerW-1:0] timer_q;

  logic [6:0] coin_val;
  logic [6:0] sel_price;
  logic [7:0] coin_sum;
  logic       coin_ok;
  logic       sel_ok;

  always_comb begin
    coin_val = 7'd0;
    unique case (coin_i)
      2'b01:   coin_val = 7'd5;
      2'b10:   coin_val = 7'd10;
      2'b11:   coin_val = 7'd25;
      default: coin_val = 7'd0;
    endcase

    sel_price = 7'd0;
    unique case (sel_i)
      2'b00:   sel_price = 7'(PRICE_A);
      2'b01:   sel_price = 7'(PRICE_B);
      2'b10:   sel_price = 7'(PRICE_C);
      default: sel_price = 7'd0;
    endcase

    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok  = coin_valid_i && (coin_i != 2'b00) && (coin_sum <= 8'(MAX_CREDIT));
    // Selection is judged on the registered credit, before any coin arriving this cycle.
    sel_ok   = sel_valid_i && (sel_i != 2'b11) && (credit_q >= sel_price);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      credit_q       <= 7'd0;
      price_q        <= 7'd0;
      vend_sel_q     <= 2'b00;
      vend_go_q      <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
      timer_q        <= '0;
    end else begin
      coin_reject_q  <= 1'b0;
      change_pulse_q <= 1'b0;
      case (state_q)
        StIdle, StCollect: begin
          if (coin_ok) begin
            credit_q <= coin_sum[6:0];
          end else if (coin_valid_i) begin
            coin_reject_q <= 1'b1;
          end
          if (state_q == StIdle) begin
            if (coin_ok) state_q <= StCollect;
          end else if (cancel_i) begin
            state_q <= StChange;
            busy_q  <= 1'b1;
          end else if (sel_ok) begin
            state_q    <= StVend;
            vend_go_q  <= 1'b1;
            vend_sel_q <= sel_i;
            price_q    <= sel_price;
            timer_q    <= '0;
            busy_q     <= 1'b1;
          end
        end

        StVend: begin
          if (coin_valid_i) coin_reject_q <= 1'b1;
          if (vend_ack_i) begin
            vend_go_q <= 1'b0;
            credit_q  <= credit_q - price_q;
            if (credit_q != price_q) begin
              state_q <= StChange;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
            // Dispenser never answered: keep the whole credit and refund it.
            vend_go_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= StChange;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StChange: begin
          if (coin_valid_i) coin_reject_q <= 1'b1;
          if (credit_q == 7'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            change_pulse_q <= 1'b1;
            credit_q       <= credit_q - 7'd5;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vend_go_o      = vend_go_q;
  assign vend_sel_o     = vend_sel_q;
  assign coin_reject_o  = coin_reject_q;
  assign change_pulse_o = change_pulse_q;
  assign credit_o       = credit_q;
  assign busy_o         = busy_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_coffee_order_controller.sv
// Directed bench for coffee_order_controller with default prices (15/20/25), cap 75, timeout 16.
module tb_coffee_order_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       vend_ack;
  logic       vend_go;
  logic [1:0] vend_sel;
  logic       coin_reject;
  logic       change_pulse;
  logic [6:0] credit;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int n;

  coffee_order_controller dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid_i  (coin_valid),
    .coin_i        (coin),
    .sel_valid_i   (sel_valid),
    .sel_i         (sel),
    .cancel_i      (cancel),
    .vend_ack_i    (vend_ack),
    .vend_go_o     (vend_go),
    .vend_sel_o    (vend_sel),
    .coin_reject_o (coin_reject),
    .change_pulse_o(change_pulse),
    .credit_o      (credit),
    .busy_o        (busy),
    .fault_o       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0;
    coin       = 2'b00;
    sel_valid  = 1'b0;
    sel        = 2'b00;
    cancel     = 1'b0;
    vend_ack   = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin_valid = 1'b1;
    coin       = c;
    tick();
    clear_inputs();
  endtask

  task automatic select(input logic [1:0] s);
    sel_valid = 1'b1;
    sel       = s;
    tick();
    clear_inputs();
  endtask

  task automatic ack();
    vend_ack = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Count change pulses until busy falls, bounded at 40 cycles.
  task automatic count_pulses(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (change_pulse) cnt++;
      if (!busy) break;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_credit", credit, 0);
    check("reset_vend_go", vend_go, 0);
    check("reset_vend_sel", vend_sel, 0);
    check("reset_reject", coin_reject, 0);
    check("reset_change", change_pulse, 0);
    check("reset_busy", busy, 0);
    check("reset_fault", fault, 0);

    // 10 + 10, drink A, one 5-unit change pulse.
    put_coin(2'b10);
    check("a_credit10", credit, 10);
    put_coin(2'b10);
    check("a_credit20", credit, 20);
    select(2'b00);
    check("a_vend_go", vend_go, 1);
    check("a_vend_sel", vend_sel, 0);
    check("a_busy", busy, 1);
    tick();
    check("a_vend_go_hold", vend_go, 1);
    ack();
    check("a_go_low", vend_go, 0);
    check("a_credit5", credit, 5);
    count_pulses(n);
    check("a_pulses", n, 1);
    check("a_credit0", credit, 0);
    check("a_idle", busy, 0);

    // Short credit ignored, then topped up for drink C; coin during VEND refused.
    put_coin(2'b10);
    select(2'b10);
    check("c_ignored_go", vend_go, 0);
    check("c_ignored_credit", credit, 10);
    put_coin(2'b11);
    check("c_credit35", credit, 35);
    select(2'b10);
    check("c_vend_go", vend_go, 1);
    check("c_vend_sel", vend_sel, 2);
    put_coin(2'b01);
    check("c_vend_reject", coin_reject, 1);
    check("c_vend_credit", credit, 35);
    ack();
    check("c_credit10", credit, 10);
    count_pulses(n);
    check("c_pulses", n, 2);

    // Credit cap and invalid coin.
    put_coin(2'b11);
    put_coin(2'b11);
    put_coin(2'b11);
    check("cap_credit75", credit, 75);
    put_coin(2'b01);
    check("cap_reject", coin_reject, 1);
    check("cap_credit", credit, 75);
    tick();
    check("cap_reject_pulse", coin_reject, 0);
    cancel = 1'b1;
    tick();
    clear_inputs();
    check("cap_cancel_busy", busy, 1);
    count_pulses(n);
    check("cap_pulses", n, 15);
    put_coin(2'b00);
    check("inv_reject", coin_reject, 1);
    check("inv_credit", credit, 0);
    select(2'b00);
    check("idle_sel_ignored", vend_go, 0);

    // Coin and selection together: selection uses pre-coin credit.
    put_coin(2'b10);
    coin_valid = 1'b1;
    coin       = 2'b01;
    sel_valid  = 1'b1;
    sel        = 2'b00;
    tick();
    clear_inputs();
    check("same_short_go", vend_go, 0);
    check("same_short_credit", credit, 15);
    coin_valid = 1'b1;
    coin       = 2'b10;
    sel_valid  = 1'b1;
    sel        = 2'b00;
    tick();
    clear_inputs();
    check("same_ok_go", vend_go, 1);
    check("same_ok_credit", credit, 25);
    ack();
    check("same_ok_remain", credit, 10);
    count_pulses(n);
    check("same_ok_pulses", n, 2);

    // Dispenser timeout on drink B.
    put_coin(2'b10);
    put_coin(2'b10);
    select(2'b01);
    check("to_vend_sel", vend_sel, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (!vend_go) break;
    end
    check("to_go_cycles", n, 16);
    check("to_fault", fault, 1);
    check("to_credit", credit, 20);
    count_pulses(n);
    check("to_pulses", n, 4);
    check("to_fault_sticky", fault, 1);

    // Cancel beats selection; coin that cycle still lands.
    put_coin(2'b10);
    put_coin(2'b01);
    check("cx_credit15", credit, 15);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    sel        = 2'b00;
    coin_valid = 1'b1;
    coin       = 2'b10;
    tick();
    clear_inputs();
    check("cx_no_go", vend_go, 0);
    check("cx_credit25", credit, 25);
    count_pulses(n);
    check("cx_pulses", n, 5);

    // Reset mid-CHANGE abandons the refund.
    put_coin(2'b11);
    put_coin(2'b11);
    cancel = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();
    check("rc_pulsing", change_pulse, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rc_credit", credit, 0);
    check("rc_change", change_pulse, 0);
    check("rc_busy", busy, 0);
    check("rc_fault", fault, 0);
    check("rc_vend_go", vend_go, 0);
    check("rc_vend_sel", vend_sel, 0);
    check("rc_reject", coin_reject, 0);
    tick();
    check("rc_no_refund", change_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coffee_order_controller.md
COFFEE_ORDER_CONTROLLER -- requirements
Module: coffee_order_controller

Interface
REQ-001 SHALL have parameter PRICE_A, default 15, price of drink A in credit units.
REQ-002 SHALL have parameter PRICE_B, default 20, price of drink B.
REQ-003 SHALL have parameter PRICE_C, default 25, price of drink C.
REQ-004 SHALL have parameter MAX_CREDIT, default 75, maximum credit held.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 16, cycles allowed for vend_ack after vend_go rises.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port coin_valid, input, 1, coin present this cycle.
REQ-009 SHALL have port coin, input, 2, coin value: 01=5, 10=10, 11=25, 00=invalid.
REQ-010 SHALL have port sel_valid, input, 1, drink selection present this cycle.
REQ-011 SHALL have port sel, input, 2, selection: 00=A, 01=B, 10=C, 11=invalid.
REQ-012 SHALL have port cancel, input, 1, customer refund request.
REQ-013 SHALL have port vend_ack, input, 1, dispenser completed the drink.
REQ-014 SHALL have port vend_go, output, 1, vend request to dispenser.
REQ-015 SHALL have port vend_sel, output, 2, drink code to dispenser, same encoding as sel.
REQ-016 SHALL have port coin_reject, output, 1, one-cycle pulse returning a refused coin.
REQ-017 SHALL have port change_pulse, output, 1, each high cycle ejects 5 units.
REQ-018 SHALL have port credit, output, 7, current credit.
REQ-019 SHALL have port busy, output, 1, high in VEND or CHANGE.
REQ-020 SHALL have port fault, output, 1, sticky dispenser-timeout flag.

Function
REQ-021 SHALL implement states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-022 SHALL, in IDLE/COLLECT, add a valid coin to credit one cycle after coin_valid, if credit+value <= MAX_CREDIT; IDLE->COLLECT on acceptance.
REQ-023 SHALL pulse coin_reject one cycle after coin_valid for: coin=00, cap overflow, or any coin in VEND/CHANGE; credit unchanged.
REQ-024 SHALL ignore sel_valid in IDLE, with sel=11, or when registered credit < selected price.
REQ-025 SHALL, in COLLECT with qualifying selection, enter VEND next cycle with vend_go=1, vend_sel=sel latched, price latched.
REQ-026 SHALL, for a coin and a selection in the same cycle, evaluate the selection against pre-coin credit and also apply the coin.
REQ-027 SHALL give cancel priority over sel_valid in COLLECT: COLLECT->CHANGE, the selection discarded; coins that cycle still follow REQ-022.
REQ-028 SHALL ignore cancel and sel_valid in VEND and CHANGE.
REQ-029 SHALL hold vend_go and vend_sel stable in VEND until vend_ack; vend_go low the cycle after vend_ack.
REQ-030 SHALL, on vend_ack, subtract the latched price from credit; go to CHANGE if remainder > 0, else IDLE.
REQ-031 SHALL count cycles in VEND; if ACK_TIMEOUT elapse without vend_ack, drop vend_go, set fault, keep full credit, enter CHANGE.
REQ-032 SHALL, in CHANGE, assert change_pulse each cycle and decrement credit by 5; at credit 0 enter IDLE with change_pulse low.
REQ-033 SHALL keep credit a multiple of 5, never above MAX_CREDIT, never negative.

Reset
REQ-034 SHALL, with rst high at a clock edge, enter IDLE with credit=0, vend_go=0, vend_sel=00, coin_reject=0, change_pulse=0, busy=0, fault=0, timeout counter=0.
REQ-035 SHALL, on rst mid-VEND or mid-CHANGE, abandon the transaction without refund; rst outranks all inputs.

Verification
REQ-036 Coins 10,10, sel=A -> credit 20, vend_go with vend_sel=00; vend_ack -> credit 5, one change_pulse, IDLE.
REQ-037 Credit 10, sel=C -> ignored, no vend_go; add 25 (credit 35), sel=C -> vend; ack -> two change_pulses.
REQ-038 Credit 75, coin 5 -> coin_reject pulse, credit 75; coin=00 in IDLE -> coin_reject.
REQ-039 Credit 20, sel=B, no vend_ack for 16 cycles -> vend_go falls, fault=1, four change_pulses, IDLE, fault remains 1.
REQ-040 Credit 15 with cancel, sel=A and coin 10 in same cycle -> no vend; credit 25, five change_pulses.
REQ-041 rst asserted mid-CHANGE -> next cycle all outputs at REQ-034 values.
